// File: rtl/icache_direct_pkg.sv
// Shared bus types for the fetch port (ibus) and the cache/memory bus (cbus).
package icache_direct_pkg;

    // AXI-style transfer size: bytes per beat = 2**size
    typedef enum logic [2:0] {
        MSIZE1   = 3'd0,
        MSIZE2   = 3'd1,
        MSIZE4   = 3'd2,
        MSIZE8   = 3'd3,
        MSIZE16  = 3'd4,
        MSIZE32  = 3'd5,
        MSIZE64  = 3'd6,
        MSIZE128 = 3'd7
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2,
        AXI_BURST_RSVD  = 2'd3
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // cbus handshake: a beat transfers on every cycle where valid (from the
    // requester) and ready (from the responder) are both high; last marks the
    // final beat of a burst. The requester holds all request fields constant
    // from the first cycle of valid until the beat carrying last.
    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are answered in the same
// cycle from register storage; a miss refills the whole line with one INCR
// burst on cbus and the held request then hits on the cycle after last.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int OFS    = $clog2(LINE_WORDS * 8);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 64 - OFS - IDX_W;
    localparam int WORD_W = $clog2(LINE_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef logic [IDX_W-1:0]  index_t;
    typedef logic [WORD_W-1:0] word_t;

    state_e           state_q, state_d;
    word_t            cnt_q, cnt_d;
    index_t           idx_q, idx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    cbus_req_t        creq_q, creq_d;
    meta_t            meta_q [NUM_LINES];
    meta_t            meta_d [NUM_LINES];
    logic [63:0]      data_q [NUM_LINES][LINE_WORDS];
    logic [63:0]      data_d [NUM_LINES][LINE_WORDS];

    // Request address decode; addr[1:0] carry no information for 32-bit fetches
    index_t           req_idx;
    logic [TAG_W-1:0] req_tag;
    word_t            req_word;
    logic             req_half;
    logic             hit;
    logic [63:0]      sel_word;
    logic [1:0]       unused_addr_lsb;

    assign req_idx         = ireq.addr[OFS+IDX_W-1:OFS];
    assign req_tag         = ireq.addr[63:OFS+IDX_W];
    assign req_word        = ireq.addr[OFS-1:3];
    assign req_half        = ireq.addr[2];
    assign unused_addr_lsb = ireq.addr[1:0];
    assign sel_word        = data_q[req_idx][req_word];
    assign hit             = ireq.valid && meta_q[req_idx].valid && (meta_q[req_idx].tag == req_tag);
    assign creq            = creq_q;

    // Fetch response: only an IDLE hit answers; everything else is all-zero
    always_comb begin
        iresp = '0;
        if (state_q == ST_IDLE && hit) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = req_half ? sel_word[63:32] : sel_word[31:0];
        end
    end

    // Next-state logic: miss detection, refill beat capture, line commit on last
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        creq_d  = creq_q;
        meta_d  = meta_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (ireq.valid && !hit) begin
                    idx_d                 = req_idx;
                    tag_d                 = req_tag;
                    cnt_d                 = '0;
                    // Victim is invalidated up front so a partial line never hits
                    meta_d[req_idx].valid = 1'b0;
                    creq_d                = '0;
                    creq_d.valid          = 1'b1;
                    creq_d.is_write       = 1'b0;
                    creq_d.size           = MSIZE8;
                    creq_d.addr           = {ireq.addr[63:OFS], {OFS{1'b0}}};
                    creq_d.len            = 8'(LINE_WORDS - 1);
                    creq_d.burst          = AXI_BURST_INCR;
                    state_d               = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (cresp.ready) begin
                    data_d[idx_q][cnt_q] = cresp.data;
                    cnt_d                = cnt_q + word_t'(1);
                    if (cresp.last) begin
                        meta_d[idx_q].valid = 1'b1;
                        meta_d[idx_q].tag   = tag_q;
                        creq_d              = '0;
                        state_d             = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and metadata registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            creq_q  <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            creq_q  <= creq_d;
            meta_q  <= meta_d;
        end
    end

    // Line data storage; contents are qualified by meta valid, so no reset
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: refill, hits, conflict, back-pressure,
// reset mid-burst and a dropped request during refill.
module tb_icache_direct;
  import icache_direct_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  icache_direct dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .creq  (creq),
    .cresp (cresp)
  );

  // Expected refill request for an 8-word line of 64-bit beats
  function automatic cbus_req_t exp_req(input logic [63:0] line);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'b0;
    r.size     = MSIZE8;
    r.addr     = line;
    r.len      = 8'd7;
    r.burst    = AXI_BURST_INCR;
    return r;
  endfunction

  // Present a fetch that must miss, then check the burst request next cycle
  task automatic start_miss(input logic [63:0] a, input logic [63:0] line);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    #1;
    checks++;
    if (iresp !== '0) begin
      failures++;
      $display("FAIL miss_resp addr=%h got=%h exp=0", a, iresp);
    end
    checks++;
    if (creq.valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_no_creq addr=%h got=%b exp=0", a, creq.valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (creq !== exp_req(line)) begin
      failures++;
      $display("FAIL creq_issue got=%h exp=%h", creq, exp_req(line));
    end
  endtask

  // Memory side: nbeats beats of {seed+k, seed+k}, gap idle cycles before each
  task automatic run_burst(input logic [63:0] line, input int nbeats, input int gap,
                           input logic [31:0] seed);
    logic [31:0] v;
    for (int k = 0; k < nbeats; k++) begin
      for (int g = 0; g < gap; g++) begin
        cresp = '0;
        #1;
        checks++;
        if (creq !== exp_req(line)) begin
          failures++;
          $display("FAIL creq_hold beat=%0d got=%h exp=%h", k, creq, exp_req(line));
        end
        checks++;
        if (iresp !== '0) begin
          failures++;
          $display("FAIL refill_resp_idle beat=%0d got=%h exp=0", k, iresp);
        end
        @(negedge clk);
      end
      v           = seed + 32'(k);
      cresp.ready = 1'b1;
      cresp.last  = (k == 7);
      cresp.data  = {v, v};
      #1;
      checks++;
      if (creq !== exp_req(line)) begin
        failures++;
        $display("FAIL creq_beat beat=%0d got=%h exp=%h", k, creq, exp_req(line));
      end
      checks++;
      if (iresp !== '0) begin
        failures++;
        $display("FAIL refill_resp beat=%0d got=%h exp=0", k, iresp);
      end
      @(negedge clk);
    end
    cresp = '0;
  endtask

  // Present a fetch that must hit in the same cycle with the given data
  task automatic check_hit(input logic [63:0] a, input logic [31:0] exp_data);
    ibus_resp_t e;
    e.addr_ok  = 1'b1;
    e.data_ok  = 1'b1;
    e.data     = exp_data;
    ireq.valid = 1'b1;
    ireq.addr  = a;
    #1;
    checks++;
    if (iresp !== e) begin
      failures++;
      $display("FAIL hit addr=%h got=%h exp=%h", a, iresp, e);
    end
    checks++;
    if (creq.valid !== 1'b0) begin
      failures++;
      $display("FAIL hit_no_creq addr=%h got=%b exp=0", a, creq.valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ireq  = '0;
    cresp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (iresp !== '0) begin
      failures++;
      $display("FAIL reset_iresp got=%h exp=0", iresp);
    end
    checks++;
    if (creq !== '0) begin
      failures++;
      $display("FAIL reset_creq got=%h exp=0", creq);
    end
    @(negedge clk);
  endtask

  task automatic test_miss_refill();
    start_miss(64'h8000_0000, 64'h8000_0000);
    run_burst(64'h8000_0000, 8, 0, 32'h0);
    check_hit(64'h8000_0000, 32'h0);
  endtask

  task automatic test_hits();
    check_hit(64'h8000_0004, 32'h0);
    check_hit(64'h8000_0038, 32'h7);
    check_hit(64'h8000_003C, 32'h7);
    check_hit(64'h8000_0010, 32'h2);
    check_hit(64'h8000_0013, 32'h2);
  endtask

  task automatic test_conflict();
    start_miss(64'h8000_0400, 64'h8000_0400);
    run_burst(64'h8000_0400, 8, 0, 32'h100);
    check_hit(64'h8000_0400, 32'h100);
    check_hit(64'h8000_0424, 32'h104);
    start_miss(64'h8000_0000, 64'h8000_0000);
    run_burst(64'h8000_0000, 8, 0, 32'h500);
    check_hit(64'h8000_0000, 32'h500);
  endtask

  task automatic test_back_pressure();
    start_miss(64'h8000_0040, 64'h8000_0040);
    run_burst(64'h8000_0040, 8, 3, 32'h600);
    check_hit(64'h8000_0040, 32'h600);
    check_hit(64'h8000_007C, 32'h607);
  endtask

  task automatic test_reset_mid_burst();
    start_miss(64'h8000_0080, 64'h8000_0080);
    run_burst(64'h8000_0080, 4, 0, 32'h200);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (creq.valid !== 1'b0) begin
      failures++;
      $display("FAIL creq_after_reset got=%b exp=0", creq.valid);
    end
    checks++;
    if (iresp !== '0) begin
      failures++;
      $display("FAIL iresp_after_reset got=%h exp=0", iresp);
    end
    reset = 1'b0;
    start_miss(64'h8000_0080, 64'h8000_0080);
    run_burst(64'h8000_0080, 8, 0, 32'h300);
    check_hit(64'h8000_0080, 32'h300);
    check_hit(64'h8000_00BC, 32'h307);
    // Reset invalidated every line, including the one filled earlier
    start_miss(64'h8000_0000, 64'h8000_0000);
    run_burst(64'h8000_0000, 8, 0, 32'h700);
    check_hit(64'h8000_0004, 32'h700);
  endtask

  task automatic test_drop_valid();
    start_miss(64'h8000_00C0, 64'h8000_00C0);
    ireq.valid = 1'b0;
    run_burst(64'h8000_00C0, 8, 0, 32'h400);
    #1;
    checks++;
    if (iresp !== '0) begin
      failures++;
      $display("FAIL drop_iresp got=%h exp=0", iresp);
    end
    checks++;
    if (creq.valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_creq got=%b exp=0", creq.valid);
    end
    @(negedge clk);
    check_hit(64'h8000_00C8, 32'h401);
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hits();
    test_conflict();
    test_back_pressure();
    test_reset_mid_burst();
    test_drop_valid();
    ireq = '0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
